// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder: valid/ready word loader that serialises words one
// bit per clock toward the '1101' detector, with a one-word hold buffer.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   load_valid/ready   word handshake (ready is registers-only, never valid)
//   load_data          word to serialise, sampled only on a transfer
//   serial_out         registered serial bit, IDLE_BIT when no word shifts
//   serial_active      serial_out carries a data bit this cycle
//   word_done          pulse while the last bit of a word is on serial_out
module serial_pattern_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_BIT   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  serial_out,
   output logic                  serial_active,
   output logic                  word_done
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_shift;
   logic [DW-1:0]   w_shift_nxt;
   logic [DW-1:0]   r_hold;
   logic [DW-1:0]   w_hold_nxt;
   logic            r_hold_full;
   logic            w_hold_full_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_sout;
   logic            r_active;
   logic            r_done;
   logic            w_sout_nxt;
   logic            w_active_nxt;
   logic            w_done_nxt;
   logic            w_xfer;
   logic            w_last;
   logic [DW-1:0]   w_shifted;

   assign load_ready    = ~rst & ~r_hold_full;
   assign w_xfer        = load_valid & load_ready;
   assign w_last        = (r_cnt == LAST);
   assign serial_out    = r_sout;
   assign serial_active = r_active;
   assign word_done     = r_done;

   // The bit on the line always sits at the "first" end of r_shift.
   assign w_shifted = MSB_FIRST ? {r_shift[DW-2:0], 1'b0}
                                : {1'b0, r_shift[DW-1:1]};

   function automatic logic first_bit(input logic [DW-1:0] w);
      return MSB_FIRST ? w[DW-1] : w[0];
   endfunction

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      w_cnt_nxt       = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_shift_nxt = load_data;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               w_cnt_nxt = '0;
               // ready is low while the hold buffer is full, so a held
               // word and a new transfer never compete here
               if (r_hold_full) begin
                  w_shift_nxt     = r_hold;
                  w_hold_full_nxt = 1'b0;
               end else if (w_xfer) begin
                  w_shift_nxt = load_data;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_shift_nxt = w_shifted;
               w_cnt_nxt   = r_cnt + CW'(1);
               if (w_xfer) begin
                  w_hold_nxt      = load_data;
                  w_hold_full_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Outputs are precomputed so the line is driven straight from flops.
      w_active_nxt = (w_state_nxt == S_SHIFT);
      w_sout_nxt   = w_active_nxt ? first_bit(w_shift_nxt) : IDLE_BIT;
      w_done_nxt   = w_active_nxt & (w_cnt_nxt == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_cnt       <= '0;
         r_sout      <= IDLE_BIT;
         r_active    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sout      <= w_sout_nxt;
         r_active    <= w_active_nxt;
         r_done      <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// tb_serial_pattern_feeder: three feeders (MSB/idle0, LSB/idle0, MSB/idle1)
// share one stimulus stream and are checked against a word-queue model.
module tb_serial_pattern_feeder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic [2:0] w_ready;
   logic [2:0] w_sout;
   logic [2:0] w_act;
   logic [2:0] w_done;

   int n_chk = 0;
   int n_pass = 0;

   // model: accepted words in order, and bits already sent of the head word
   logic [7:0] m_q[$];
   int         m_pos = 0;

   always #5 clk = ~clk;

   serial_pattern_feeder #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(w_ready[0]), .serial_out(w_sout[0]),
      .serial_active(w_act[0]), .word_done(w_done[0]));

   serial_pattern_feeder #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(w_ready[1]), .serial_out(w_sout[1]),
      .serial_active(w_act[1]), .word_done(w_done[1]));

   serial_pattern_feeder #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u2 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(w_ready[2]), .serial_out(w_sout[2]),
      .serial_active(w_act[2]), .word_done(w_done[2]));

   function automatic logic m_ready();
      return !rst && (m_q.size() < 2);
   endfunction

   function automatic logic m_sout(int u);
      logic [7:0] w;
      if (m_q.size() == 0) return (u == 2);
      w = m_q[0];
      return (u != 1) ? w[7-m_pos] : w[m_pos];
   endfunction

   function automatic logic [7:0] rev8(logic [7:0] x);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = x[7-i];
      return r;
   endfunction

   // one clock edge with the inputs currently driven; the model follows it
   task automatic tick();
      logic       xfer;
      logic [7:0] d;
      xfer = m_ready() && load_valid;
      d    = load_data;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_pos = 0;
      end else begin
         if (m_q.size() > 0) begin
            m_pos++;
            if (m_pos == 8) begin
               void'(m_q.pop_front());
               m_pos = 0;
            end
         end
         if (xfer) m_q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      #1;
      n_chk++;
      if (w_ready !== 3'b000) $display("FAIL rst_ready got=%b exp=000", w_ready);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_chk++;
      if ({w_ready, w_sout, w_act, w_done} !== 12'b111_100_000_000)
         $display("FAIL reset_state got=%b exp=111100000000",
                  {w_ready, w_sout, w_act, w_done});
      else n_pass++;
   endtask

   task automatic test_single_word();
      logic [3:0] hist = 4'b0000;
      int         hits = 0;
      logic [7:0] w = 8'h0D;
      load_valid = 1'b1;
      load_data  = w;
      #1;
      n_chk++;
      if (w_ready !== 3'b111) $display("FAIL sw_ready got=%b exp=111", w_ready);
      else n_pass++;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         hist = {hist[2:0], w_sout[0]};
         if (hist == 4'b1101) hits++;
         n_chk++;
         if (i < 8) begin
            if ({w_sout[0], w_sout[2], w_act, w_done} !==
                {w[7-i], w[7-i], 3'b111, (i == 7) ? 3'b111 : 3'b000})
               $display("FAIL sw_bit%0d got=%b exp=%b", i,
                        {w_sout[0], w_sout[2], w_act, w_done},
                        {w[7-i], w[7-i], 3'b111, (i == 7) ? 3'b111 : 3'b000});
            else n_pass++;
         end else begin
            if ({w_sout, w_act, w_done} !== 9'b100_000_000)
               $display("FAIL sw_idle%0d got=%b exp=100000000", i,
                        {w_sout, w_act, w_done});
            else n_pass++;
         end
         tick();
      end
      n_chk++;
      if (hits != 1) $display("FAIL sw_detect got=%0d exp=1", hits);
      else n_pass++;
   endtask

   task automatic test_lsb_first();
      logic [7:0] e = 8'b1011_0000;
      load_valid = 1'b1;
      load_data  = 8'h0D;
      #1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         n_chk++;
         if (i < 8) begin
            if ({w_sout[1], w_act[1]} !== {e[7-i], 1'b1})
               $display("FAIL lsb_bit%0d got=%b exp=%b", i,
                        {w_sout[1], w_act[1]}, {e[7-i], 1'b1});
            else n_pass++;
         end else begin
            if ({w_sout[1], w_act[1]} !== 2'b00)
               $display("FAIL lsb_idle got=%b exp=00", {w_sout[1], w_act[1]});
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] e = {8'hDD, 8'hB0};
      load_valid = 1'b1;
      load_data  = 8'hDD;
      #1;
      tick();
      load_data = 8'hB0;
      for (int k = 0; k < 17; k++) begin
         #1;
         n_chk++;
         if (w_ready !== ((k >= 1 && k <= 7) ? 3'b000 : 3'b111))
            $display("FAIL b2b_ready%0d got=%b", k, w_ready);
         else n_pass++;
         n_chk++;
         if (k < 16) begin
            if ({w_sout[0], w_act[0], w_done[0]} !==
                {e[15-k], 1'b1, (k == 7 || k == 15)})
               $display("FAIL b2b_bit%0d got=%b exp=%b", k,
                        {w_sout[0], w_act[0], w_done[0]},
                        {e[15-k], 1'b1, (k == 7 || k == 15)});
            else n_pass++;
         end else begin
            if (w_act !== 3'b000) $display("FAIL b2b_end got=%b exp=000", w_act);
            else n_pass++;
         end
         tick();
         load_valid = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  w[3];
      int          acc[3];
      int          nacc = 0;
      int          dc[$];
      logic        s0[$];
      logic        s1[$];
      logic [23:0] g0 = '0;
      logic [23:0] g1 = '0;
      for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
      for (int c = 0; c < 40; c++) begin
         load_valid = (nacc < 3);
         load_data  = w[(nacc < 3) ? nacc : 0];
         #1;
         n_chk++;
         if (w_ready !== {3{m_ready()}})
            $display("FAIL bp_ready%0d got=%b exp=%b", c, w_ready, m_ready());
         else n_pass++;
         if (w_act[0]) s0.push_back(w_sout[0]);
         if (w_act[1]) s1.push_back(w_sout[1]);
         if (w_done[0]) dc.push_back(c);
         if (load_valid && w_ready[0]) begin
            acc[nacc] = c;
            nacc++;
         end
         tick();
      end
      load_valid = 1'b0;
      n_chk++;
      if (nacc != 3 || dc.size() != 3)
         $display("FAIL bp_counts got=%0d,%0d exp=3,3", nacc, dc.size());
      else n_pass++;
      n_chk++;
      if (nacc != 3 || dc.size() == 0 || acc[2] != dc[0] + 1)
         $display("FAIL bp_third got=%0d exp=%0d", acc[2],
                  (dc.size() > 0) ? dc[0] + 1 : -1);
      else n_pass++;
      foreach (s0[i]) g0 = {g0[22:0], s0[i]};
      foreach (s1[i]) g1 = {g1[22:0], s1[i]};
      n_chk++;
      if (s0.size() != 24 || g0 !== {w[0], w[1], w[2]})
         $display("FAIL bp_msb got=%h exp=%h", g0, {w[0], w[1], w[2]});
      else n_pass++;
      n_chk++;
      if (s1.size() != 24 || g1 !== {rev8(w[0]), rev8(w[1]), rev8(w[2])})
         $display("FAIL bp_lsb got=%h exp=%h", g1,
                  {rev8(w[0]), rev8(w[1]), rev8(w[2])});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] w = 8'h96;
      load_valid = 1'b1;
      load_data  = 8'h5A;
      #1;
      tick();
      load_data = 8'hC3;
      #1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst = (i == 2);
         #1;
         n_chk++;
         if ({w_ready, w_done} !== 6'b000_000)
            $display("FAIL rm_pre%0d got=%b exp=000000", i, {w_ready, w_done});
         else n_pass++;
         tick();
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++;
         if ({w_ready, w_sout, w_act, w_done} !== 12'b111_100_000_000)
            $display("FAIL rm_post%0d got=%b exp=111100000000", i,
                     {w_ready, w_sout, w_act, w_done});
         else n_pass++;
         tick();
      end
      load_valid = 1'b1;
      load_data  = w;
      #1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_chk++;
         if ({w_sout[0], w_act[0], w_done[0]} !== {w[7-i], 1'b1, (i == 7)})
            $display("FAIL rm_word%0d got=%b exp=%b", i,
                     {w_sout[0], w_act[0], w_done[0]}, {w[7-i], 1'b1, (i == 7)});
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_idle_high();
      load_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         n_chk++;
         if ({w_sout[2], w_act[2], w_done[2]} !== 3'b100)
            $display("FAIL idle_hi%0d got=%b exp=100", i,
                     {w_sout[2], w_act[2], w_done[2]});
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      logic [2:0] es;
      logic [2:0] ea;
      logic [2:0] ed;
      for (int c = 0; c < 800; c++) begin
         rst        = ($urandom_range(0, 99) == 0);
         load_valid = ($urandom_range(0, 9) < 6);
         load_data  = 8'($urandom);
         #1;
         for (int u = 0; u < 3; u++) begin
            es[u] = m_sout(u);
            ea[u] = (m_q.size() > 0);
            ed[u] = (m_q.size() > 0) && (m_pos == 7);
         end
         n_chk++;
         if ({w_ready, w_sout, w_act, w_done} !== {{3{m_ready()}}, es, ea, ed})
            $display("FAIL rnd%0d got=%b exp=%b", c,
                     {w_ready, w_sout, w_act, w_done},
                     {{3{m_ready()}}, es, ea, ed});
         else n_pass++;
         tick();
      end
      rst        = 1'b0;
      load_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_lsb_first();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_idle_high();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
